// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocator for the 5-port router.
// Each output (N,S,E,W,PE) runs an independent rotating-priority search over
// its request vector and registers a one-hot grant. Grants feed the crossbar
// select, output-buffer write enables and input-buffer dequeues.
// Port/input index mapping: 0=PE, 1=W, 2=E, 3=S, 4=N.

module switch_allocator #(
    parameter int RR_INIT = 0,
    parameter int NPORT   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req_to_n,
    input  logic [4:0] req_to_s,
    input  logic [4:0] req_to_e,
    input  logic [4:0] req_to_w,
    input  logic [4:0] req_to_pe,
    input  logic [4:0] out_full,
    output logic [4:0] grant_n,
    output logic [4:0] grant_s,
    output logic [4:0] grant_e,
    output logic [4:0] grant_w,
    output logic [4:0] grant_pe,
    output logic [4:0] out_we,
    output logic [4:0] in_deq
);

    localparam logic [2:0] PTR_INIT = 3'(RR_INIT);

    // Request and grant vectors gathered per output index
    logic [4:0] req_all   [NPORT];
    logic [4:0] grant_all [NPORT];

    assign req_all[4] = req_to_n;
    assign req_all[3] = req_to_s;
    assign req_all[2] = req_to_e;
    assign req_all[1] = req_to_w;
    assign req_all[0] = req_to_pe;

    assign grant_n  = grant_all[4];
    assign grant_s  = grant_all[3];
    assign grant_e  = grant_all[2];
    assign grant_w  = grant_all[1];
    assign grant_pe = grant_all[0];

    // Dequeue an input whenever any output currently holds a grant for it
    always_comb begin
        in_deq = '0;
        for (int o = 0; o < NPORT; o++) begin
            in_deq = in_deq | grant_all[o];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_out
            logic [4:0] eff;
            logic       found;
            logic [2:0] win_idx;
            logic [3:0] sum;
            logic [2:0] idx;
            logic       eligible;
            logic [4:0] grant_reg, grant_next;
            logic [2:0] ptr_reg,   ptr_next;

            // Inputs being popped this edge no longer hold a valid head flit
            assign eff = req_all[gi] & ~in_deq;

            assign out_we[gi]    = |grant_reg;
            assign grant_all[gi] = grant_reg;

            // Rotating-priority search starting at the pointer, wrapping 4 -> 0
            always_comb begin
                found   = 1'b0;
                win_idx = ptr_reg;
                sum     = '0;
                idx     = '0;
                for (int off = 0; off < NPORT; off++) begin
                    sum = {1'b0, ptr_reg} + 4'(off);
                    idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                    if (!found && eff[idx]) begin
                        found   = 1'b1;
                        win_idx = idx;
                    end
                end
            end

            // A buffer written last edge is treated as full (its flag lags a cycle)
            always_comb begin
                eligible   = !out_full[gi] && !out_we[gi] && found;
                grant_next = '0;
                ptr_next   = ptr_reg;
                if (eligible) begin
                    grant_next = 5'b00001 << win_idx;
                    ptr_next   = (win_idx == 3'd4) ? 3'd0 : 3'(win_idx + 3'd1);
                end
            end

            // Grant and pointer state, cleared asynchronously by reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_reg <= '0;
                    ptr_reg   <= PTR_INIT;
                end else begin
                    grant_reg <= grant_next;
                    ptr_reg   <= ptr_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator (RR_INIT = 0).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_switch_allocator;

    logic       clk;
    logic       rst_n;
    logic [4:0] req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe;
    logic [4:0] out_full;
    logic [4:0] grant_n, grant_s, grant_e, grant_w, grant_pe;
    logic [4:0] out_we, in_deq;

    int checks = 0;
    int errors = 0;

    switch_allocator #(.RR_INIT(0), .NPORT(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_to_n  (req_to_n),
        .req_to_s  (req_to_s),
        .req_to_e  (req_to_e),
        .req_to_w  (req_to_w),
        .req_to_pe (req_to_pe),
        .out_full  (out_full),
        .grant_n   (grant_n),
        .grant_s   (grant_s),
        .grant_e   (grant_e),
        .grant_w   (grant_w),
        .grant_pe  (grant_pe),
        .out_we    (out_we),
        .in_deq    (in_deq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short
    initial begin
        #20000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
        $display("check %-14s observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_to_n  = '0;
        req_to_s  = '0;
        req_to_e  = '0;
        req_to_w  = '0;
        req_to_pe = '0;
        out_full  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [4:0] rr_exp [11];

    initial begin
        rr_exp = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
                   5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset holds everything at zero even with all requests asserted
        req_to_n = 5'b11111; req_to_s = 5'b11111; req_to_e = 5'b11111;
        req_to_w = 5'b11111; req_to_pe = 5'b11111;
        @(negedge clk);
        step();
        check("rst_grant_n",  grant_n,  5'b00000);
        check("rst_grant_pe", grant_pe, 5'b00000);
        check("rst_out_we",   out_we,   5'b00000);
        check("rst_in_deq",   in_deq,   5'b00000);
        rst_n = 1'b1;
        step();
        check("init_grant_pe", grant_pe, 5'b00001);
        check("init_grant_n",  grant_n,  5'b00001);
        check("init_grant_e",  grant_e,  5'b00001);
        check("init_out_we",   out_we,   5'b11111);
        check("init_in_deq",   in_deq,   5'b00001);

        // Single request to E, bubble, then pointer at 3 picks input 3 over 2
        do_reset();
        req_to_e = 5'b00100;
        step();
        check("single_grant_e", grant_e, 5'b00100);
        check("single_out_we",  out_we,  5'b00100);
        check("single_in_deq",  in_deq,  5'b00100);
        req_to_e = 5'b00000;
        step();
        check("bubble_grant_e", grant_e, 5'b00000);
        check("bubble_out_we",  out_we,  5'b00000);
        req_to_e = 5'b01100;
        step();
        check("ptr_e_is_3",     grant_e, 5'b01000);

        // Round-robin with all inputs requesting PE
        do_reset();
        req_to_pe = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            step();
            check($sformatf("rr_pe_%0d", i), grant_pe, rr_exp[i]);
        end

        // Backpressure: full output blocks N, then grants when drained
        do_reset();
        req_to_n = 5'b01000;
        out_full = 5'b10000;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_grant_n_%0d", i), grant_n, 5'b00000);
        end
        out_full = 5'b00000;
        step();
        check("bp_release_n", grant_n, 5'b01000);

        // Full rising in the same cycle as a request blocks the grant
        do_reset();
        req_to_w = 5'b00010;
        out_full = 5'b00010;
        step();
        check("full_same_w", grant_w, 5'b00000);

        // Parallel grants on three outputs in one cycle
        do_reset();
        req_to_n = 5'b00001;
        req_to_s = 5'b10000;
        req_to_w = 5'b00100;
        step();
        check("par_grant_n", grant_n, 5'b00001);
        check("par_grant_s", grant_s, 5'b10000);
        check("par_grant_w", grant_w, 5'b00100);
        check("par_in_deq",  in_deq,  5'b10101);
        check("par_out_we",  out_we,  5'b11010);

        // Asynchronous reset between edges clears a live grant
        do_reset();
        req_to_s = 5'b00010;
        step();
        check("ar_grant_s", grant_s, 5'b00010);
        #2 rst_n = 1'b0;
        #1;
        check("ar_clr_grant_s", grant_s, 5'b00000);
        check("ar_clr_out_we",  out_we,  5'b00000);
        check("ar_clr_in_deq",  in_deq,  5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        req_to_s = 5'b00110;
        step();
        check("ar_ptr_s_init", grant_s, 5'b00010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
